// File: rtl/commit_trace_buffer.sv
// Retirement tracer: records every writeback commit into a circular buffer,
// stops recording after a programmable number of finish pulses, then drains
// the recorded trace oldest-first over a valid/ready stream.
module commit_trace_buffer #(
  parameter int DEPTH        = 16,
  parameter int CYC_W        = 16,
  parameter int WRAP_MODE    = 1,
  parameter int FINISH_COUNT = 3
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Pause,
  input  logic                     commit_valid,
  input  logic [31:0]              commit_pc,
  input  logic [31:0]              commit_instr,
  input  logic [4:0]               commit_rdid,
  input  logic [31:0]              commit_data,
  input  logic                     finish,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [31:0]              rd_pc,
  output logic [31:0]              rd_instr,
  output logic [4:0]               rd_rdid,
  output logic [31:0]              rd_data,
  output logic [CYC_W-1:0]         rd_cycle,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     trace_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = (FINISH_COUNT > 1) ? $clog2(FINISH_COUNT) : 1;
  localparam logic [FW-1:0] FIN_LAST = FW'(FINISH_COUNT - 1);
  localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);

  localparam logic [1:0] S_CAPTURE = 2'd0;
  localparam logic [1:0] S_DRAIN   = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic [4:0]       rdid;
    logic [31:0]      data;
    logic [CYC_W-1:0] cyc;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [1:0]       state;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CYC_W-1:0] cyc;
  logic [FW-1:0]    fin_cnt;
  logic             commit, full, do_wr, xfer;
  logic [AW:0]      cnt_after;
  entry_t           head;

  // Qualify commits/beats; in stop mode a full buffer drops the new entry.
  always_comb begin
    commit    = (state == S_CAPTURE) & commit_valid & ~Pause;
    full      = (count == FULL);
    do_wr     = commit & ((WRAP_MODE != 0) | ~full);
    xfer      = rd_valid & rd_ready;
    cnt_after = count - {{AW{1'b0}}, xfer};
    head      = mem[rd_ptr];
  end

  // Trace storage; not reset, occupancy is tracked by count alone.
  always_ff @(posedge CLK) begin
    if (!RST && do_wr)
      mem[wr_ptr] <= '{pc: commit_pc, instr: commit_instr, rdid: commit_rdid,
                       data: commit_data, cyc: cyc};
  end

  // Pointers, occupancy, cycle stamp, finish counting and capture/drain/done sequencing.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_CAPTURE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      cyc        <= '0;
      fin_cnt    <= '0;
      overflow   <= 1'b0;
      trace_done <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      cyc <= cyc + 1'b1;
      case (state)
        S_CAPTURE: begin
          if (commit) begin
            if (!full) begin
              wr_ptr <= wr_ptr + 1'b1;
              count  <= count + 1'b1;
            end else begin
              overflow <= 1'b1;
              // Overwrite mode: oldest entry is sacrificed, occupancy stays full.
              if (WRAP_MODE != 0) begin
                wr_ptr <= wr_ptr + 1'b1;
                rd_ptr <= rd_ptr + 1'b1;
              end
            end
          end
          if (finish) begin
            if (fin_cnt == FIN_LAST) state <= S_DRAIN;
            else                     fin_cnt <= fin_cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (xfer) begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= cnt_after;
          end
          if (cnt_after == '0) begin
            state      <= S_DONE;
            trace_done <= 1'b1;
            rd_valid   <= 1'b0;
          end else begin
            rd_valid   <= 1'b1;
          end
        end
        default: begin
          rd_valid <= 1'b0;
        end
      endcase
    end
  end

  // Drain data is the head entry, forced to zero when no beat is offered.
  assign rd_pc    = rd_valid ? head.pc    : '0;
  assign rd_instr = rd_valid ? head.instr : '0;
  assign rd_rdid  = rd_valid ? head.rdid  : '0;
  assign rd_data  = rd_valid ? head.data  : '0;
  assign rd_cycle = rd_valid ? head.cyc   : '0;
endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
Synthesizable retirement tracer that sits beside the pipelined RISC-V core at the writeback stage.
- Captures every valid writeback commit (pc, instr, rdid, data, cycle stamp) into a parametrised circular buffer.
- Detects end-of-program from the core's finish pulses.
- Drains the captured trace oldest-first over a valid/ready stream toward the UART or debug path.
- Gives on-chip visibility equivalent to a simulation cycle dump.

Parameters:
DEPTH, 16, number of trace entries; power of two, >=2.
CYC_W, 16, width of the free-running cycle stamp.
WRAP_MODE, 1, 1 = overwrite oldest entry when full (keep newest DEPTH); 0 = stop capturing when full and flag overflow.
FINISH_COUNT, 3, number of finish pulses that end capture.

Ports:
CLK  in  1  clock; all logic on rising edge.
RST  in  1  synchronous active-high reset.
Pause  in  1  while high, commits are ignored; the cycle counter still runs.
commit_valid  in  1  writeback stage holds a valid retiring instruction this cycle.
commit_pc  in  32  PC of the retiring instruction.
commit_instr  in  32  raw instruction word.
commit_rdid  in  5  destination register index.
commit_data  in  32  value written to rd.
finish  in  1  one-cycle pulse from the core's finish logic.
rd_ready  in  1  consumer accepts the drain beat.
rd_valid  out  1  drain beat valid.
rd_pc  out  32  drained PC.
rd_instr  out  32  drained instruction word.
rd_rdid  out  5  drained rd index.
rd_data  out  32  drained writeback data.
rd_cycle  out  CYC_W  cycle stamp of the drained entry.
count  out  $clog2(DEPTH)+1  number of valid entries held.
overflow  out  1  sticky; set once any commit has been dropped or overwritten.
trace_done  out  1  drain complete.

Behaviour:
Reset
- RST is sampled on the CLK edge.
- Resets: state=CAPTURE, wr_ptr=rd_ptr=0, count=0, cycle counter=0, finish counter=0, overflow=0, trace_done=0, rd_valid=0.
- rd_* data outputs read 0 during and after reset.
- RST asserted mid-drain aborts the drain; the buffer contents are considered empty.

Cycle counter
- Increments by 1 every cycle out of reset in every state.
- Wraps modulo 2^CYC_W.
- An entry is stamped with the counter value of the cycle in which it is captured.

State CAPTURE
- A commit is the condition commit_valid & !Pause.
- On a commit, the entry is written at wr_ptr, wr_ptr advances modulo DEPTH, and count increments.
- When full (count==DEPTH):
  - WRAP_MODE=1: the entry is still written, rd_ptr advances, count stays DEPTH, overflow<=1.
  - WRAP_MODE=0: the entry is dropped, pointers and count are unchanged, overflow<=1.
- Each finish pulse increments the finish counter.
- When the counter reaches FINISH_COUNT, the state moves to DRAIN on the next edge.
- A commit in the same cycle as the final finish pulse is captured; it is the last entry.
- After that, commits are ignored until reset.

State DRAIN
- rd_valid=1 while count>0, registered one cycle after entering DRAIN.
- rd_* present the entry at rd_ptr.
- A beat transfers when rd_valid & rd_ready: rd_ptr advances modulo DEPTH, count decrements, and the next entry is presented on the following cycle (one beat per cycle max).
- rd_* stay stable while rd_valid & !rd_ready.
- When count reaches 0, or on entry if count==0, the state moves to DONE.

State DONE
- trace_done=1 and rd_valid=0.
- The block is idle until RST; finish and commits are ignored.

Read/write ordering
- Entries are always drained oldest-first by capture order.
- No read and write ever occur in the same cycle, because capture and drain are separate states.

Test Plan:
1. Reset behaviour: RST=1 for 2 cycles with commit_valid=1 -> count=0, rd_valid=0, overflow=0, trace_done=0; cycle stamp of the first post-reset commit is 0 when that commit arrives on the first cycle after RST drops.
2. Basic capture/drain: DEPTH=16; 5 commits with pc=0,4,8,12,16, then 3 finish pulses, rd_ready=1 -> 5 beats, pc 0..16 in order, cycle stamps matching the commit cycles; trace_done=1 the cycle after the last beat; overflow=0.
3. Wrap mode: WRAP_MODE=1, 20 commits with pc=4*i, then finish x3 -> 16 beats with pc=16..76; overflow=1.
4. Stop mode: WRAP_MODE=0, 20 commits -> 16 beats with pc=0..60; overflow=1; count=16 holds during the last 4 commits.
5. Pause and backpressure:
   - Commits with Pause=1 -> not captured.
   - During drain, rd_ready toggles 1,0,0,1 -> rd_pc holds while stalled; no beat duplicated or lost.
6. Edge cases:
   - Commit coinciding with the 3rd finish -> captured and drained last.
   - RST mid-drain -> rd_valid=0, count=0 the next cycle, state CAPTURE.
